// File: rtl/seg7_frame_decoder.sv
// Decodes a settled 4-digit active-low 7-segment frame into one 16-bit value per distinct stable frame; FIB_CHECK_EN adds a Fibonacci sequence check.
// Latency: a frame captured at edge 0 is presented after edge STABLE_CYCLES+1.
// Backpressure: out_valid holds until out_ready; a frame that settles while the slot is full is dropped and sets sticky overrun.
module seg7_frame_decoder #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [6:0]  disp1,
   input  logic [6:0]  disp2,
   input  logic [6:0]  disp3,
   input  logic [6:0]  disp4,
   output logic [15:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_err,
   output logic [3:0]  bad_mask,
   output logic        overrun,
   output logic        seq_err
);

   localparam int             CW       = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0]  C_STABLE = CW'(STABLE_CYCLES);
   localparam logic [CW-1:0]  C_ONE    = CW'(1);
   localparam logic [27:0]    C_BLANK  = 28'hFFFFFFF;

   typedef enum logic {IDLE, SETTLE} state_t;

   state_t         r_state;
   logic [27:0]    r_sample;
   logic [27:0]    r_cand;
   logic [27:0]    r_last;
   logic [CW-1:0]  r_cnt;
   logic [15:0]    r_out_data;
   logic           r_out_valid;
   logic           r_out_err;
   logic [3:0]     r_bad_mask;
   logic           r_overrun;

   logic [4:0]     w_dec [4];
   logic [15:0]    w_data;
   logic [3:0]     w_bad;
   logic           w_err;
   logic           w_emit;
   logic           w_slot_free;

   // Returns {pattern_ok, nibble}; unknown patterns decode to nibble 0.
   function automatic logic [4:0] seg_decode(input logic [6:0] seg);
      case (seg)
         7'h40:   seg_decode = 5'h10;
         7'h79:   seg_decode = 5'h11;
         7'h24:   seg_decode = 5'h12;
         7'h30:   seg_decode = 5'h13;
         7'h19:   seg_decode = 5'h14;
         7'h12:   seg_decode = 5'h15;
         7'h02:   seg_decode = 5'h16;
         7'h78:   seg_decode = 5'h17;
         7'h00:   seg_decode = 5'h18;
         7'h10:   seg_decode = 5'h19;
         7'h08:   seg_decode = 5'h1A;
         7'h03:   seg_decode = 5'h1B;
         7'h46:   seg_decode = 5'h1C;
         7'h21:   seg_decode = 5'h1D;
         7'h06:   seg_decode = 5'h1E;
         7'h0E:   seg_decode = 5'h1F;
         default: seg_decode = 5'h00;
      endcase
   endfunction

   genvar g;
   generate
      for (g = 0; g < 4; g++) begin : g_dec
         assign w_dec[g]           = seg_decode(r_cand[7*g +: 7]);
         assign w_data[4*g +: 4]   = w_dec[g][3:0];
         assign w_bad[g]           = ~w_dec[g][4];
      end
   endgenerate

   assign w_err       = |w_bad;
   assign w_emit      = (r_state == SETTLE) && (r_sample == r_cand) &&
                        (r_cnt == C_STABLE) && (r_cand != r_last);
   assign w_slot_free = !r_out_valid || out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_sample    <= C_BLANK;
         r_cand      <= C_BLANK;
         r_last      <= C_BLANK;
         r_cnt       <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_out_err   <= 1'b0;
         r_bad_mask  <= '0;
         r_overrun   <= 1'b0;
      end else begin
         r_sample <= {disp4, disp3, disp2, disp1};

         case (r_state)
            IDLE: begin
               if (r_sample != r_last) begin
                  r_state <= SETTLE;
                  r_cand  <= r_sample;
                  r_cnt   <= C_ONE;
               end
            end
            SETTLE: begin
               if (r_sample != r_cand) begin
                  r_cand <= r_sample;
                  r_cnt  <= C_ONE;
               end else if (r_cnt == C_STABLE) begin
                  // last_frame moves even when the frame is dropped, so it is never re-emitted
                  r_last  <= r_cand;
                  r_state <= IDLE;
               end else begin
                  r_cnt <= r_cnt + C_ONE;
               end
            end
            default: r_state <= IDLE;
         endcase

         if (w_emit && w_slot_free) begin
            r_out_data  <= w_data;
            r_out_err   <= w_err;
            r_bad_mask  <= w_bad;
            r_out_valid <= 1'b1;
         end else if (w_emit) begin
            r_overrun <= 1'b1;
         end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign out_err   = r_out_err;
   assign bad_mask  = r_bad_mask;
   assign overrun   = r_overrun;

`ifdef FIB_CHECK_EN
   logic [15:0] r_p0;
   logic [15:0] r_p1;
   logic [1:0]  r_n;
   logic        r_seq_err;

   // History only tracks frames actually presented without decode errors.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_p0      <= '0;
         r_p1      <= '0;
         r_n       <= '0;
         r_seq_err <= 1'b0;
      end else if (w_emit && w_slot_free && !w_err) begin
         if ((r_n == 2'd2) && (w_data != 16'(r_p0 + r_p1))) begin
            r_seq_err <= 1'b1;
         end
         r_p0 <= r_p1;
         r_p1 <= w_data;
         if (r_n != 2'd2) begin
            r_n <= r_n + 2'd1;
         end
      end
   end

   assign seq_err = r_seq_err;
`else
   assign seq_err = 1'b0;
`endif

endmodule
